// File: rtl/dram_uart_tx_pkg.sv
// Shared types and UART frame constants for the DRAM-to-UART block transmitter.
// Both FSM state encodings live here so the top and the serializer agree on them.
package dram_uart_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } top_state_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    // DONE deliberately excluded: busy drops in the same cycle done pulses.
    function automatic logic is_busy(input top_state_t s);
        case (s)
            ST_FETCH, ST_LOAD, ST_SEND, ST_NEXT: is_busy = 1'b1;
            default:                             is_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dram_uart_tx_serializer.sv
// UART 8N1 serializer: START/DATA/STOP with its own baud counter.
// tx is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx_serializer
    import dram_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    ser_state_t    state_r;
    ser_state_t    state_nx_s;
    logic [CW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          bit_end_s;
    logic          last_data_s;
    logic          last_stop_s;

    // Next-state decode and end-of-frame strobe for the top FSM
    always_comb begin
        bit_end_s   = (baud_cnt_r == BAUD_MAX);
        last_data_s = (bit_idx_r == 3'(DATA_BITS - 1));
        last_stop_s = (bit_idx_r == 3'(STOP_BITS - 1));
        state_nx_s  = state_r;
        case (state_r)
            SER_IDLE:  if (load) state_nx_s = SER_START; else state_nx_s = SER_IDLE;
            SER_START: if (bit_end_s) state_nx_s = SER_DATA; else state_nx_s = SER_START;
            SER_DATA:  if (bit_end_s && last_data_s) state_nx_s = SER_STOP; else state_nx_s = SER_DATA;
            SER_STOP:  if (bit_end_s && last_stop_s) state_nx_s = SER_IDLE; else state_nx_s = SER_STOP;
            default:   state_nx_s = SER_IDLE;
        endcase
        frame_done = (state_r == SER_STOP) && bit_end_s && last_stop_s;
    end

    // State, baud counter, bit index, shift register and the tx line flop
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= SER_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx         <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                SER_START: tx <= 1'b0;
                SER_DATA:  tx <= shift_r[0];
                default:   tx <= 1'b1;
            endcase
            if ((state_r == SER_IDLE) || bit_end_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + 1'b1;
            end
            // bit_idx_r is reused to count stop bits, so it must wrap to 0 on leaving DATA
            if ((state_r == SER_IDLE) && load) begin
                shift_r   <= byte_in;
                bit_idx_r <= 3'd0;
            end else if (bit_end_s && (state_r == SER_DATA)) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_idx_r <= last_data_s ? 3'd0 : bit_idx_r + 3'd1;
            end else if (bit_end_s && (state_r == SER_STOP)) begin
                bit_idx_r <= last_stop_s ? 3'd0 : bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end
    end

endmodule

// File: rtl/dram_uart_tx.sv
// Streams NUM_BYTES bytes from DRAM, ascending from START_ADDR, out over UART 8N1.
// Owns DRAM_address while busy; the serializer handles bit timing.
module dram_uart_tx
    import dram_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [15:0] START_ADDR   = 16'h0000,
    parameter int          NUM_BYTES    = 65536,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_Tx,
    input  logic [7:0]  DRAM_data,
    output logic [15:0] DRAM_address,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [LW-1:0] LAT_MAX   = LW'(READ_LATENCY - 1);
    localparam logic [16:0]   LAST_BYTE = 17'(NUM_BYTES - 1);

    top_state_t    state_r;
    top_state_t    state_nx_s;
    logic [LW-1:0] lat_cnt_r;
    logic [16:0]   byte_cnt_r;
    logic          load_s;
    logic          frame_done_s;

    // Next-state decode; start_Tx outside IDLE is simply not looked at
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_Tx) state_nx_s = ST_FETCH; else state_nx_s = ST_IDLE;
            ST_FETCH: if (lat_cnt_r == LAT_MAX) state_nx_s = ST_LOAD; else state_nx_s = ST_FETCH;
            ST_LOAD:  state_nx_s = ST_SEND;
            ST_SEND: begin
                if (frame_done_s) begin
                    if (byte_cnt_r == LAST_BYTE) state_nx_s = ST_DONE;
                    else                         state_nx_s = ST_NEXT;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_NEXT:  state_nx_s = ST_FETCH;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
        load_s = (state_r == ST_LOAD);
    end

    // State register, registered status outputs, read latency, address and byte counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            lat_cnt_r    <= '0;
            byte_cnt_r   <= 17'd0;
            DRAM_address <= START_ADDR;
        end else begin
            state_r <= state_nx_s;
            busy    <= is_busy(state_nx_s);
            done    <= (state_nx_s == ST_DONE);
            if ((state_r == ST_FETCH) && (lat_cnt_r != LAT_MAX)) begin
                lat_cnt_r <= lat_cnt_r + 1'b1;
            end else begin
                lat_cnt_r <= '0;
            end
            if ((state_r == ST_IDLE) && start_Tx) begin
                DRAM_address <= START_ADDR;
                byte_cnt_r   <= 17'd0;
            end else if (state_r == ST_NEXT) begin
                DRAM_address <= DRAM_address + 16'd1;
                byte_cnt_r   <= byte_cnt_r + 17'd1;
            end else begin
                DRAM_address <= DRAM_address;
                byte_cnt_r   <= byte_cnt_r;
            end
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock      (clock),
        .reset      (reset),
        .load       (load_s),
        .byte_in    (DRAM_data),
        .tx         (tx),
        .frame_done (frame_done_s)
    );

endmodule
